// File: rtl/mem_ctrl.sv
// mem_ctrl: sequencer and arbiter for a single byte-wide RAM port shared by
// instruction fetch (IF) and the MEM stage.
//
// Every access is broken into consecutive little-endian byte transactions on
// the RAM port. MEM has fixed priority over IF. Completion is reported with a
// one-cycle done pulse to whichever requester owned the access.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   if_req/if_addr           IF word fetch request and byte address
//   if_data/if_done          fetched word (held) and one-cycle completion pulse
//   mem_req/mem_we/mem_len   MEM request, store enable, size (0=B,1=H,2/3=W)
//   mem_addr/mem_wdata       MEM byte address and store data (low bytes used)
//   mem_rdata/mem_done       zero-extended load data (held) and completion pulse
//   ram_addr/ram_wr/ram_dout RAM byte address, write strobe, write byte
//   ram_din                  RAM read byte, valid the cycle after its address
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        ph_reg;        // byte phase within the current access
  logic [2:0]        n_reg;         // number of bytes in the current access
  logic              owner_mem_reg; // 1 = MEM owns the access, 0 = IF
  logic [ADDR_W-1:0] base_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [7:0]        rbuf_reg [NB];
  logic [DATA_W-1:0] read_word;
  logic [2:0]        mem_n;
  logic [1:0]        nxt_lane;
  logic [ADDR_W-1:0] nxt_addr;

  always_comb begin
    case (mem_len)
      2'd0:    mem_n = 3'd1;
      2'd1:    mem_n = 3'd2;
      default: mem_n = 3'd4;
    endcase
  end

  assign nxt_lane = ph_reg[1:0] + 2'd1;
  assign nxt_addr = base_reg + ADDR_W'(ph_reg + 3'd1);

  // Byte lanes of the read result. The last byte of a read arrives on ram_din
  // in the same cycle the result is published, so that lane is bypassed
  // straight from ram_din instead of waiting for the lane register.
  // Lanes are cleared in IDLE so unused high bytes read back as zero.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rbuf_reg[gi] <= 8'd0;
        end else if (state_reg == IDLE) begin
          rbuf_reg[gi] <= 8'd0;
        end else if (state_reg == READ && ph_reg == 3'(gi + 1)) begin
          rbuf_reg[gi] <= ram_din;
        end
      end

      assign read_word[8*gi +: 8] =
        (state_reg == READ && ph_reg == 3'(gi + 1)) ? ram_din : rbuf_reg[gi];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (mem_req) begin
          state_next = mem_we ? WRITE : READ;
        end else if (if_req) begin
          state_next = READ;
        end
      end
      // Reads take one extra tail cycle to capture the final byte.
      READ:    if (ph_reg == n_reg) state_next = DONE;
      WRITE:   if (ph_reg == n_reg - 3'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_reg        <= 3'd0;
      n_reg         <= 3'd0;
      owner_mem_reg <= 1'b0;
      base_reg      <= '0;
      wdata_reg     <= '0;
      if_data       <= '0;
      if_done       <= 1'b0;
      mem_rdata     <= '0;
      mem_done      <= 1'b0;
      ram_addr      <= '0;
      ram_wr        <= 1'b0;
      ram_dout      <= 8'd0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          ph_reg   <= 3'd0;
          ram_addr <= '0;
          ram_wr   <= 1'b0;
          ram_dout <= 8'd0;
          if (mem_req) begin
            owner_mem_reg <= 1'b1;
            base_reg      <= mem_addr;
            n_reg         <= mem_n;
            wdata_reg     <= mem_wdata;
            ram_addr      <= mem_addr;
            ram_wr        <= mem_we;
            ram_dout      <= mem_we ? mem_wdata[7:0] : 8'd0;
          end else if (if_req) begin
            owner_mem_reg <= 1'b0;
            base_reg      <= if_addr;
            n_reg         <= 3'd4;
            wdata_reg     <= '0;
            ram_addr      <= if_addr;
          end
        end
        READ: begin
          ph_reg <= ph_reg + 3'd1;
          if (ph_reg == n_reg) begin
            if (owner_mem_reg) begin
              mem_rdata <= read_word;
              mem_done  <= 1'b1;
            end else begin
              if_data <= read_word;
              if_done <= 1'b1;
            end
            ram_addr <= '0;
          end else if (ph_reg + 3'd1 < n_reg) begin
            ram_addr <= nxt_addr;
          end else begin
            ram_addr <= '0;
          end
        end
        WRITE: begin
          ph_reg <= ph_reg + 3'd1;
          if (ph_reg == n_reg - 3'd1) begin
            ram_wr   <= 1'b0;
            ram_addr <= '0;
            ram_dout <= 8'd0;
            mem_done <= 1'b1;
          end else begin
            ram_addr <= nxt_addr;
            ram_dout <= wdata_reg[{nxt_lane, 3'b000} +: 8];
          end
        end
        default: begin
          ram_addr <= '0;
          ram_wr   <= 1'b0;
          ram_dout <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl.
// A small RAM model returns fixed byte contents one cycle after the address.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  int checks;
  int errors;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_data   (if_data),
    .if_done   (if_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_len   (mem_len),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .ram_addr  (ram_addr),
    .ram_wr    (ram_wr),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: ram_byte = 8'h11;
      32'h0000_0101: ram_byte = 8'h22;
      32'h0000_0102: ram_byte = 8'h33;
      32'h0000_0103: ram_byte = 8'h44;
      32'h0000_0007: ram_byte = 8'hF0;
      32'hFFFF_FFFE: ram_byte = 8'hA1;
      32'hFFFF_FFFF: ram_byte = 8'hB2;
      32'h0000_0000: ram_byte = 8'hC3;
      32'h0000_0001: ram_byte = 8'hD4;
      default:       ram_byte = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // RAM read data is valid the cycle after the address is presented.
  always @(posedge clk) ram_din <= ram_byte(ram_addr);

  task automatic test_reset;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_data, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: if_data=%h if_done=%b mem_rdata=%h mem_done=%b ram_addr=%h ram_wr=%b ram_dout=%h, required all 0",
               if_data, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ram_wr !== 1'b0 || ram_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_idle: ram_wr=%b ram_addr=%h, required 0/0", ram_wr, ram_addr);
    end
    $display("reset: done");
  endtask

  task automatic test_if_read;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (ram_addr !== 32'h100 + 32'(k) || ram_wr !== 1'b0 || if_done !== 1'b0) begin
        errors++;
        $display("FAIL if_read_addr%0d: ram_addr=%h ram_wr=%b if_done=%b, required %h/0/0",
                 k, ram_addr, ram_wr, if_done, 32'h100 + 32'(k));
      end
    end
    @(negedge clk);
    checks++;
    if (ram_addr !== 32'h0 || if_done !== 1'b0) begin
      errors++;
      $display("FAIL if_read_tail: ram_addr=%h if_done=%b, required 0/0", ram_addr, if_done);
    end
    @(negedge clk);
    checks++;
    if (if_done !== 1'b1 || if_data !== 32'h4433_2211 || mem_done !== 1'b0) begin
      errors++;
      $display("FAIL if_read_done: if_done=%b if_data=%h mem_done=%b, required 1/44332211/0",
               if_done, if_data, mem_done);
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_done !== 1'b0 || if_data !== 32'h4433_2211) begin
      errors++;
      $display("FAIL if_read_after: if_done=%b if_data=%h, required 0/44332211", if_done, if_data);
    end
    $display("if_read: addr=00000100 data=%h", if_data);
  endtask

  // MEM load of n bytes starting at addr; expects exp on mem_rdata with mem_done.
  task automatic mem_rd(input logic [31:0] addr, input logic [1:0] len, input int n,
                        input logic [31:0] exp, input string name);
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_len = len; mem_addr = addr;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if (ram_addr !== addr + 32'(k) || ram_wr !== 1'b0 || mem_done !== 1'b0) begin
        errors++;
        $display("FAIL %s_addr%0d: ram_addr=%h ram_wr=%b mem_done=%b, required %h/0/0",
                 name, k, ram_addr, ram_wr, mem_done, addr + 32'(k));
      end
    end
    @(negedge clk);
    checks++;
    if (ram_addr !== 32'h0 || mem_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_tail: ram_addr=%h mem_done=%b, required 0/0", name, ram_addr, mem_done);
    end
    @(negedge clk);
    checks++;
    if (mem_done !== 1'b1 || mem_rdata !== exp || if_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: mem_done=%b mem_rdata=%h if_done=%b, required 1/%h/0",
               name, mem_done, mem_rdata, if_done, exp);
    end
    mem_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: mem_done=%b after done cycle, required 0", name, mem_done);
    end
    $display("%s: addr=%h len=%0d rdata=%h", name, addr, len, mem_rdata);
  endtask

  task automatic test_byte_load;
    mem_rd(32'h7, 2'd0, 1, 32'h0000_00F0, "byte_load");
  endtask

  task automatic test_half_store;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd1; mem_addr = 32'h20; mem_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    checks++;
    if (ram_wr !== 1'b1 || ram_addr !== 32'h20 || ram_dout !== 8'hDD) begin
      errors++;
      $display("FAIL half_store_b0: wr=%b addr=%h dout=%h, required 1/00000020/dd", ram_wr, ram_addr, ram_dout);
    end
    @(negedge clk);
    checks++;
    if (ram_wr !== 1'b1 || ram_addr !== 32'h21 || ram_dout !== 8'hCC || mem_done !== 1'b0) begin
      errors++;
      $display("FAIL half_store_b1: wr=%b addr=%h dout=%h done=%b, required 1/00000021/cc/0",
               ram_wr, ram_addr, ram_dout, mem_done);
    end
    @(negedge clk);
    checks++;
    if (ram_wr !== 1'b0 || mem_done !== 1'b1 || mem_rdata !== 32'h0000_00F0) begin
      errors++;
      $display("FAIL half_store_done: wr=%b done=%b rdata=%h, required 0/1/000000f0",
               ram_wr, mem_done, mem_rdata);
    end
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_wr !== 1'b0 || mem_done !== 1'b0) begin
      errors++;
      $display("FAIL half_store_after: wr=%b done=%b, required 0/0", ram_wr, mem_done);
    end
    $display("half_store: addr=00000020 wdata=aabbccdd");
  endtask

  task automatic test_arbitration;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h7;
    if_req = 1'b1; if_addr = 32'h104;
    @(negedge clk);
    checks++;
    if (ram_addr !== 32'h7) begin
      errors++;
      $display("FAIL arb_mem_first: ram_addr=%h, required 00000007", ram_addr);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_done !== 1'b1 || if_done !== 1'b0 || mem_rdata !== 32'h0000_00F0) begin
      errors++;
      $display("FAIL arb_mem_done: mem_done=%b if_done=%b rdata=%h, required 1/0/000000f0",
               mem_done, if_done, mem_rdata);
    end
    mem_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_addr !== 32'h0 || mem_done !== 1'b0) begin
      errors++;
      $display("FAIL arb_idle: ram_addr=%h mem_done=%b, required 0/0", ram_addr, mem_done);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (ram_addr !== 32'h104 + 32'(k) || mem_done !== 1'b0 || if_done !== 1'b0) begin
        errors++;
        $display("FAIL arb_if_addr%0d: ram_addr=%h mem_done=%b if_done=%b, required %h/0/0",
                 k, ram_addr, mem_done, if_done, 32'h104 + 32'(k));
      end
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (if_done !== 1'b1 || if_data !== 32'h5D5C_5F5E || mem_done !== 1'b0) begin
      errors++;
      $display("FAIL arb_if_done: if_done=%b if_data=%h mem_done=%b, required 1/5d5c5f5e/0",
               if_done, if_data, mem_done);
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_done !== 1'b0 || mem_rdata !== 32'h0000_00F0) begin
      errors++;
      $display("FAIL arb_after: if_done=%b mem_rdata=%h, required 0/000000f0", if_done, mem_rdata);
    end
    $display("arbitration: mem then if, if_data=%h", if_data);
  endtask

  task automatic test_wrap;
    mem_rd(32'hFFFF_FFFE, 2'd2, 4, 32'hD4C3_B2A1, "wrap_len2");
    mem_rd(32'hFFFF_FFFE, 2'd3, 4, 32'hD4C3_B2A1, "wrap_len3");
  endtask

  task automatic test_reset_during_write;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h40; mem_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (ram_wr !== 1'b1 || ram_addr !== 32'h40 || ram_dout !== 8'h78) begin
      errors++;
      $display("FAIL rstw_b0: wr=%b addr=%h dout=%h, required 1/00000040/78", ram_wr, ram_addr, ram_dout);
    end
    @(negedge clk);
    checks++;
    if (ram_wr !== 1'b1 || ram_addr !== 32'h41 || ram_dout !== 8'h56) begin
      errors++;
      $display("FAIL rstw_b1: wr=%b addr=%h dout=%h, required 1/00000041/56", ram_wr, ram_addr, ram_dout);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({if_data, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout} !== '0) begin
      errors++;
      $display("FAIL rstw_async: if_data=%h mem_rdata=%h done=%b%b ram_addr=%h ram_wr=%b ram_dout=%h, required all 0",
               if_data, mem_rdata, if_done, mem_done, ram_addr, ram_wr, ram_dout);
    end
    mem_req = 1'b0; mem_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (mem_done !== 1'b0 || ram_wr !== 1'b0) begin
        errors++;
        $display("FAIL rstw_quiet%0d: mem_done=%b ram_wr=%b, required 0/0", k, mem_done, ram_wr);
      end
    end
    $display("reset_during_write: write abandoned");
    mem_rd(32'h7, 2'd0, 1, 32'h0000_00F0, "post_reset_load");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_if_read;
    test_byte_load;
    test_half_store;
    test_arbitration;
    test_wrap;
    test_reset_during_write;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
